// File: rtl/serial_full_adder_if.sv
// ---------------------------------------------------------------------------
// serial_full_adder_if
//   Bundles the operand/result bus and start/busy/done handshake of the
//   bit-serial adder so the requester and the adder share one connection.
//
//   Signals
//     start  requester -> adder  request; only honoured while busy=0
//     a, b   requester -> adder  operands, captured on an accepted start
//     cin    requester -> adder  carry-in, captured on an accepted start
//     busy   adder -> requester  addition in progress
//     done   adder -> requester  one-cycle pulse, sum/cout freshly valid
//     sum    adder -> requester  a+b+cin modulo 2^WIDTH
//     cout   adder -> requester  carry out of the top bit
//
//   Modports
//     master  the side that issues additions (drives start/a/b/cin)
//     slave   the adder itself (drives busy/done/sum/cout)
// ---------------------------------------------------------------------------
interface serial_full_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_full_adder.sv
// ---------------------------------------------------------------------------
// serial_full_adder
//   Bit-serial WIDTH-bit adder. Operands are loaded in parallel, then fed LSB
//   first, one bit per clock, through a single full-adder cell built from two
//   half adders and an OR. The finished sum and carry are presented in
//   parallel and held until the next completion.
//
//   Parameters
//     WIDTH   operand/result width, 1..32
//
//   Ports
//     clk     rising-edge clock
//     rst_n   synchronous active-low reset; wins over everything else
//     bus     serial_full_adder_if.slave
//               start/a/b/cin in, busy/done/sum/cout out
//
//   Timing
//     start accepted on edge k -> done=1 with new sum/cout after edge k+WIDTH.
//     A start seen during the done cycle reloads immediately, so back-to-back
//     operations complete every WIDTH cycles. start is ignored while busy.
// ---------------------------------------------------------------------------
module serial_full_adder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_full_adder_if.slave   bus
);

  // Counter must be able to hold WIDTH-1 without ever wrapping.
  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q,   opa_d;
  logic [WIDTH-1:0] opb_q,   opb_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // -------------------------------------------------------------------------
  // Full-adder cell: two half adders plus an OR on their carries.
  // -------------------------------------------------------------------------
  logic             ha1_s, ha1_c;
  logic             ha2_s, ha2_c;
  logic             bit_s, bit_c;
  logic [WIDTH-1:0] res_shift;

  assign ha1_s = opa_q[0] ^ opb_q[0];
  assign ha1_c = opa_q[0] & opb_q[0];
  assign ha2_s = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;
  assign bit_s = ha2_s;
  assign bit_c = ha1_c | ha2_c;

  // New sum bit enters at the MSB; after WIDTH steps the LSB-first stream has
  // landed in the right order. Written as a shift of the concatenation so the
  // same expression also covers WIDTH=1.
  assign res_shift = WIDTH'({bit_s, res_q} >> 1);

  // -------------------------------------------------------------------------
  // Next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        // From DONE with no new request we fall back to IDLE; a request in
        // either state loads the operands right away.
        if (state_q == DONE) begin
          state_d = IDLE;
        end
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.cin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = res_shift;
        carry_d = bit_c;
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the result in the same edge it is formed.
          sum_d   = res_shift;
          cout_d  = bit_c;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = cnt_q;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_full_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_full_adder
//   Directed bench for serial_full_adder at WIDTH=8 and WIDTH=1. Expected
//   {cout,sum} values are computed from the operands when a start is driven,
//   queued, and compared when the adder raises done.
// ---------------------------------------------------------------------------
module tb_serial_full_adder;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  serial_full_adder_if #(.WIDTH(8)) if8 ();
  serial_full_adder_if #(.WIDTH(1)) if1 ();

  serial_full_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8.slave)
  );

  serial_full_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] sb8[$];
  logic [1:0] sb1[$];
  logic [7:0] last_sum8;
  logic       last_cout8;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request on the 8-bit adder; returns after the load edge.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    if8.a     = a;
    if8.b     = b;
    if8.cin   = cin;
    if8.start = 1'b1;
    sb8.push_back(9'(a) + 9'(b) + 9'(cin));
    tick();
    if8.start = 1'b0;
    // Operands are don't-care once loaded.
    if8.a     = 8'($urandom);
    if8.b     = 8'($urandom);
    if8.cin   = 1'($urandom);
    check("w8 busy after load", 32'(if8.busy), 32'd1);
  endtask

  // Wait (bounded) for done, expecting it after exactly edges_left edges.
  task automatic wait_done8(input int edges_left, input string tag);
    logic [8:0] exp;
    int n = 0;
    while (if8.done !== 1'b1 && n < edges_left + 4) begin
      check({tag, " busy while running"}, 32'(if8.busy), 32'd1);
      check({tag, " sum held"}, {23'd0, if8.cout, if8.sum}, {23'd0, last_cout8, last_sum8});
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(edges_left));
    check({tag, " done"}, 32'(if8.done), 32'd1);
    check({tag, " busy at done"}, 32'(if8.busy), 32'd0);
    if (sb8.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
    end else begin
      exp = sb8.pop_front();
      check({tag, " result"}, {23'd0, if8.cout, if8.sum}, {23'd0, exp});
      last_sum8  = exp[7:0];
      last_cout8 = exp[8];
      $display("%s: sum=%02h cout=%0b after %0d edges", tag, if8.sum, if8.cout, n);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] exp1;
    rst_n     = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
    last_sum8 = '0;   last_cout8 = 1'b0;

    // Reset state
    tick(); tick();
    check("reset w8 busy", 32'(if8.busy), 32'd0);
    check("reset w8 done", 32'(if8.done), 32'd0);
    check("reset w8 sum/cout", {23'd0, if8.cout, if8.sum}, 32'd0);
    check("reset w1 outputs", {28'd0, if1.busy, if1.done, if1.cout, if1.sum}, 32'd0);
    rst_n = 1'b1;
    tick();

    // T1: basic add
    start8(8'h3C, 8'h0F, 1'b0);
    wait_done8(8, "T1");
    tick();
    check("T1 done one cycle", 32'(if8.done), 32'd0);

    // T2: overflow cases
    start8(8'hFF, 8'h01, 1'b0);
    wait_done8(8, "T2a");
    tick();
    start8(8'hFF, 8'hFF, 1'b1);
    wait_done8(8, "T2b");
    tick();

    // T3: start during RUN is ignored
    start8(8'h3C, 8'h0F, 1'b0);
    tick(); tick();
    if8.a = 8'h55; if8.b = 8'hAA; if8.cin = 1'b1; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    wait_done8(5, "T3");
    tick();
    check("T3 single done", 32'(if8.done), 32'd0);
    check("T3 back to idle", 32'(if8.busy), 32'd0);

    // T4: back-to-back start in the DONE cycle
    start8(8'h12, 8'h34, 1'b1);
    wait_done8(8, "T4 first");
    start8(8'h80, 8'h80, 1'b0);
    check("T4 first result held", {23'd0, if8.cout, if8.sum}, 32'h047);
    check("T4 done dropped", 32'(if8.done), 32'd0);
    wait_done8(8, "T4 second");
    tick();

    // T5: reset mid-RUN aborts
    start8(8'h77, 8'h11, 1'b0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb8.pop_back());
    last_sum8 = '0; last_cout8 = 1'b0;
    check("T5 busy cleared", 32'(if8.busy), 32'd0);
    check("T5 sum/cout cleared", {23'd0, if8.cout, if8.sum}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("T5 no done", 32'(if8.done), 32'd0);
      tick();
    end
    start8(8'hA5, 8'h5A, 1'b1);
    wait_done8(8, "T5 after reset");
    tick();

    // Mixed operand patterns
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      start8(ra, rb, 1'(i));
      wait_done8(8, "rand");
    end
    tick();

    // T6: WIDTH=1, all operand combinations, back-to-back loads
    for (int i = 0; i < 8; i++) begin
      if1.a     = 1'(i >> 2);
      if1.b     = 1'(i >> 1);
      if1.cin   = 1'(i);
      if1.start = 1'b1;
      sb1.push_back(2'(if1.a) + 2'(if1.b) + 2'(if1.cin));
      tick();
      if1.start = 1'b0;
      check("T6 busy after load", 32'(if1.busy), 32'd1);
      check("T6 no early done", 32'(if1.done), 32'd0);
      tick();
      check("T6 done next edge", 32'(if1.done), 32'd1);
      check("T6 busy at done", 32'(if1.busy), 32'd0);
      exp1 = sb1.pop_front();
      check("T6 result", {30'd0, if1.cout, if1.sum}, {30'd0, exp1});
      $display("T6 a=%0b b=%0b cin=%0b: sum=%0b cout=%0b", 1'(i >> 2), 1'(i >> 1), 1'(i), if1.sum, if1.cout);
    end
    tick();
    check("T6 idle", {30'd0, if1.busy, if1.done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
